// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// Decode-stage additions: op_t, reg_t, de_state_t and DE_IMM_REG_DEFAULT.
package idli_pkg;

  typedef logic [15:0] data_t;
  typedef logic [1:0]  ctr_t;
  typedef logic [3:0]  op_t;
  typedef logic [3:0]  reg_t;

  typedef enum logic [0:0] {
    DE_OPC = 1'b0,
    DE_IMM = 1'b1
  } de_state_t;

  // RB field value marking that an immediate word follows the opcode word.
  localparam reg_t DE_IMM_REG_DEFAULT = 4'hF;

endpackage

// File: rtl/idli_de_pc_m.sv
// Word address counter for the decode stage.
// Built only when IDLI_DE_PC_EN is defined: loads the redirect target and
// advances by one for every word the decoder captures (wraps at 16 bits).
module idli_de_pc_m
  import idli_pkg::*;
(
  input  logic  i_pc_gck,
  input  logic  i_pc_rst_n,
  input  logic  i_pc_redirect,
  input  data_t i_pc_redirect_pc,
  input  logic  i_pc_capture,
  output data_t o_pc_cnt
);

  data_t cnt_q;
  data_t cnt_d;

  // Next address: redirect target wins, otherwise step on each captured word.
  always_comb begin
    cnt_d = cnt_q;
    if (i_pc_redirect) begin
      cnt_d = i_pc_redirect_pc;
    end else if (i_pc_capture) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
    if (!i_pc_rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_pc_cnt = cnt_q;

endmodule

// File: rtl/idli_decode_m.sv
// Decode stage behind the SQI memory interface.
// Captures words qualified by i_de_instr_vld, splits them into fields,
// gathers an optional trailing immediate and holds one instruction until
// execute acknowledges it. Redirect flushes held and half-collected state.
// Optional feature: IDLI_DE_PC_EN adds i_de_redirect_pc / o_de_pc.
module idli_decode_m
  import idli_pkg::*;
#(
  parameter reg_t IMM_REG = DE_IMM_REG_DEFAULT
) (
  input  logic  i_de_gck,
  input  logic  i_de_rst_n,
  input  ctr_t  i_de_ctr,
  input  data_t i_de_instr,
  input  logic  i_de_instr_vld,
  input  logic  i_de_redirect,
  input  logic  i_de_ack,
`ifdef IDLI_DE_PC_EN
  input  data_t i_de_redirect_pc,
  output data_t o_de_pc,
`endif
  output logic  o_de_vld,
  output op_t   o_de_op,
  output reg_t  o_de_rd,
  output reg_t  o_de_ra,
  output reg_t  o_de_rb,
  output logic  o_de_has_imm,
  output data_t o_de_imm,
  output logic  o_de_ovf
);

  // Capture is qualified by i_de_instr_vld alone; the phase counter is not needed.
  logic unused_ctr_s;
  assign unused_ctr_s = ^i_de_ctr;

  de_state_t state_q, state_d;
  op_t       stg_op_q, stg_op_d;
  reg_t      stg_rd_q, stg_rd_d;
  reg_t      stg_ra_q, stg_ra_d;
  reg_t      stg_rb_q, stg_rb_d;

  logic      vld_q, vld_d;
  op_t       op_q, op_d;
  reg_t      rd_q, rd_d;
  reg_t      ra_q, ra_d;
  reg_t      rb_q, rb_d;
  logic      has_imm_q, has_imm_d;
  data_t     imm_q, imm_d;
  logic      ovf_q, ovf_d;
  logic      publish_s;

`ifdef IDLI_DE_PC_EN
  data_t     pc_cnt_s;
  data_t     stg_pc_q, stg_pc_d;
  data_t     pc_q, pc_d;

  idli_de_pc_m u_pc (
    .i_pc_gck         (i_de_gck),
    .i_pc_rst_n       (i_de_rst_n),
    .i_pc_redirect    (i_de_redirect),
    .i_pc_redirect_pc (i_de_redirect_pc),
    .i_pc_capture     (i_de_instr_vld & ~i_de_redirect),
    .o_pc_cnt         (pc_cnt_s)
  );
`endif

  // Next-state: staging/publishing of words, hold/ack, overflow and redirect flush.
  always_comb begin
    state_d   = state_q;
    stg_op_d  = stg_op_q;
    stg_rd_d  = stg_rd_q;
    stg_ra_d  = stg_ra_q;
    stg_rb_d  = stg_rb_q;
    vld_d     = vld_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    has_imm_d = has_imm_q;
    imm_d     = imm_q;
    ovf_d     = ovf_q;
    publish_s = 1'b0;
`ifdef IDLI_DE_PC_EN
    stg_pc_d  = stg_pc_q;
    pc_d      = pc_q;
`endif

    if (i_de_redirect) begin
      // Flush: drop any coincident word, ignore any coincident ack.
      state_d  = DE_OPC;
      vld_d    = 1'b0;
      stg_op_d = 4'h0;
      stg_rd_d = 4'h0;
      stg_ra_d = 4'h0;
      stg_rb_d = 4'h0;
`ifdef IDLI_DE_PC_EN
      stg_pc_d = 16'h0000;
`endif
    end else begin
      if (i_de_instr_vld) begin
        case (state_q)
          DE_OPC: begin
            if (i_de_instr[3:0] == IMM_REG) begin
              stg_op_d = i_de_instr[15:12];
              stg_rd_d = i_de_instr[11:8];
              stg_ra_d = i_de_instr[7:4];
              stg_rb_d = i_de_instr[3:0];
              state_d  = DE_IMM;
`ifdef IDLI_DE_PC_EN
              stg_pc_d = pc_cnt_s;
`endif
            end else begin
              publish_s = 1'b1;
              op_d      = i_de_instr[15:12];
              rd_d      = i_de_instr[11:8];
              ra_d      = i_de_instr[7:4];
              rb_d      = i_de_instr[3:0];
              has_imm_d = 1'b0;
              imm_d     = 16'h0000;
`ifdef IDLI_DE_PC_EN
              pc_d      = pc_cnt_s;
`endif
            end
          end
          DE_IMM: begin
            publish_s = 1'b1;
            op_d      = stg_op_q;
            rd_d      = stg_rd_q;
            ra_d      = stg_ra_q;
            rb_d      = stg_rb_q;
            has_imm_d = 1'b1;
            imm_d     = i_de_instr;
            state_d   = DE_OPC;
`ifdef IDLI_DE_PC_EN
            pc_d      = stg_pc_q;
`endif
          end
          default: begin
            state_d = DE_OPC;
          end
        endcase
      end else begin
        publish_s = 1'b0;
      end

      // An ack on the publish edge frees the slot, so only an unacked hold overflows.
      if (publish_s) begin
        vld_d = 1'b1;
        if (vld_q && !i_de_ack) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end else if (i_de_ack) begin
        vld_d = 1'b0;
      end else begin
        vld_d = vld_q;
      end
    end
  end

  // State, staging and output registers.
  always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      state_q   <= DE_OPC;
      stg_op_q  <= 4'h0;
      stg_rd_q  <= 4'h0;
      stg_ra_q  <= 4'h0;
      stg_rb_q  <= 4'h0;
      vld_q     <= 1'b0;
      op_q      <= 4'h0;
      rd_q      <= 4'h0;
      ra_q      <= 4'h0;
      rb_q      <= 4'h0;
      has_imm_q <= 1'b0;
      imm_q     <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_op_q  <= stg_op_d;
      stg_rd_q  <= stg_rd_d;
      stg_ra_q  <= stg_ra_d;
      stg_rb_q  <= stg_rb_d;
      vld_q     <= vld_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      has_imm_q <= has_imm_d;
      imm_q     <= imm_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef IDLI_DE_PC_EN
  // Opcode-word address: staged with the opcode, published with the fields.
  always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      stg_pc_q <= 16'h0000;
      pc_q     <= 16'h0000;
    end else begin
      stg_pc_q <= stg_pc_d;
      pc_q     <= pc_d;
    end
  end

  assign o_de_pc = pc_q;
`endif

  assign o_de_vld     = vld_q;
  assign o_de_op      = op_q;
  assign o_de_rd      = rd_q;
  assign o_de_ra      = ra_q;
  assign o_de_rb      = rb_q;
  assign o_de_has_imm = has_imm_q;
  assign o_de_imm     = imm_q;
  assign o_de_ovf     = ovf_q;

endmodule

// File: tb/tb_idli_decode_m.sv
// Self-checking bench for idli_decode_m: directed scenarios followed by
// randomized traffic, all compared against an instruction-level model.
// Define IDLI_DE_PC_EN to also exercise the PC feature.
module tb_idli_decode_m;
  import idli_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  ctr_t  ctr;
  data_t instr;
  logic  instr_vld;
  logic  redirect;
  logic  ack;
  logic  de_vld;
  op_t   de_op;
  reg_t  de_rd, de_ra, de_rb;
  logic  de_has_imm;
  data_t de_imm;
  logic  de_ovf;
`ifdef IDLI_DE_PC_EN
  data_t rpc;
  data_t de_pc;
`endif

  always #5 clk = ~clk;

  idli_decode_m dut (
    .i_de_gck         (clk),
    .i_de_rst_n       (rst_n),
    .i_de_ctr         (ctr),
    .i_de_instr       (instr),
    .i_de_instr_vld   (instr_vld),
    .i_de_redirect    (redirect),
    .i_de_ack         (ack),
`ifdef IDLI_DE_PC_EN
    .i_de_redirect_pc (rpc),
    .o_de_pc          (de_pc),
`endif
    .o_de_vld         (de_vld),
    .o_de_op          (de_op),
    .o_de_rd          (de_rd),
    .o_de_ra          (de_ra),
    .o_de_rb          (de_rb),
    .o_de_has_imm     (de_has_imm),
    .o_de_imm         (de_imm),
    .o_de_ovf         (de_ovf)
  );

  int total = 0;
  int bad   = 0;
  ctr_t ctr_cnt;

  // Instruction-level reference: one held instruction plus an optional pending opcode word.
  logic  m_vld, m_ovf, m_pend, m_has_imm;
  data_t m_word, m_imm, m_opw;
  data_t m_pc_cnt, m_opw_pc, m_pc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_ovf = 1'b0; m_pend = 1'b0; m_has_imm = 1'b0;
    m_word = 16'h0; m_imm = 16'h0; m_opw = 16'h0;
    m_pc_cnt = 16'h0; m_opw_pc = 16'h0; m_pc = 16'h0;
  endtask

  task automatic model_step(input logic v, input data_t w, input logic r, input logic a, input data_t rp);
    logic pub;
    pub = 1'b0;
    if (r) begin
      m_vld = 1'b0;
      m_pend = 1'b0;
      m_pc_cnt = rp;
    end else begin
      if (v) begin
        if (!m_pend && w[3:0] == 4'hF) begin
          m_pend = 1'b1; m_opw = w; m_opw_pc = m_pc_cnt;
        end else if (m_pend) begin
          pub = 1'b1; m_word = m_opw; m_imm = w; m_has_imm = 1'b1; m_pc = m_opw_pc; m_pend = 1'b0;
        end else begin
          pub = 1'b1; m_word = w; m_imm = 16'h0; m_has_imm = 1'b0; m_pc = m_pc_cnt;
        end
        m_pc_cnt = m_pc_cnt + 16'd1;
      end
      if (pub) begin
        if (m_vld && !a) m_ovf = 1'b1;
        m_vld = 1'b1;
      end else if (a) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("vld", {15'h0, de_vld}, {15'h0, m_vld});
    chk("ovf", {15'h0, de_ovf}, {15'h0, m_ovf});
    if (m_vld) begin
      chk("op", {12'h0, de_op}, {12'h0, m_word[15:12]});
      chk("rd", {12'h0, de_rd}, {12'h0, m_word[11:8]});
      chk("ra", {12'h0, de_ra}, {12'h0, m_word[7:4]});
      chk("rb", {12'h0, de_rb}, {12'h0, m_word[3:0]});
      chk("has_imm", {15'h0, de_has_imm}, {15'h0, m_has_imm});
      chk("imm", de_imm, m_imm);
`ifdef IDLI_DE_PC_EN
      chk("pc", de_pc, m_pc);
`endif
    end
  endtask

  task automatic tick(input logic v, input data_t w, input logic r, input logic a);
    data_t rp;
    @(negedge clk);
    ctr = ctr_cnt; instr_vld = v; instr = w; redirect = r; ack = a;
`ifdef IDLI_DE_PC_EN
    rp = rpc;
`else
    rp = 16'h0;
`endif
    @(posedge clk);
    model_step(v, w, r, a, rp);
    #1;
    check_all();
    ctr_cnt = ctr_cnt + 2'd1;
  endtask

  // Idle until the ctr==3 slot, then present the word there.
  task automatic word(input data_t w, input logic r, input logic a);
    while (ctr_cnt != 2'd3) tick(1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b1, w, r, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_vld = 1'b0; instr = 16'h0; redirect = 1'b0; ack = 1'b0; ctr = 2'd0;
    #1;
    model_reset();
    chk("rst_vld", {15'h0, de_vld}, 16'h0);
    chk("rst_op", {12'h0, de_op}, 16'h0);
    chk("rst_has_imm", {15'h0, de_has_imm}, 16'h0);
    chk("rst_imm", de_imm, 16'h0);
    chk("rst_ovf", {15'h0, de_ovf}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ctr_cnt = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; instr_vld = 1'b0; instr = 16'h0; redirect = 1'b0; ack = 1'b0; ctr = 2'd0;
`ifdef IDLI_DE_PC_EN
    rpc = 16'h0;
`endif
    ctr_cnt = 2'd0;
    model_reset();
    #12;
    do_reset();

    // Plain instruction, acked two cycles later.
    word(16'h3127, 1'b0, 1'b0);
    chk("t1_vld", {15'h0, de_vld}, 16'h1);
    chk("t1_op", {12'h0, de_op}, 16'h3);
    chk("t1_rd", {12'h0, de_rd}, 16'h1);
    chk("t1_ra", {12'h0, de_ra}, 16'h2);
    chk("t1_rb", {12'h0, de_rb}, 16'h7);
    chk("t1_has_imm", {15'h0, de_has_imm}, 16'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t1_ack", {15'h0, de_vld}, 16'h0);

    // Opcode plus immediate.
    word(16'h512F, 1'b0, 1'b0);
    chk("t2_novld", {15'h0, de_vld}, 16'h0);
    word(16'hBEEF, 1'b0, 1'b0);
    chk("t2_vld", {15'h0, de_vld}, 16'h1);
    chk("t2_op", {12'h0, de_op}, 16'h5);
    chk("t2_rb", {12'h0, de_rb}, 16'hF);
    chk("t2_has_imm", {15'h0, de_has_imm}, 16'h1);
    chk("t2_imm", de_imm, 16'hBEEF);
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Redirect discards a half-collected instruction.
    word(16'h412F, 1'b0, 1'b0);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    word(16'h2345, 1'b0, 1'b0);
    chk("t3_op", {12'h0, de_op}, 16'h2);
    chk("t3_rd", {12'h0, de_rd}, 16'h3);
    chk("t3_ra", {12'h0, de_ra}, 16'h4);
    chk("t3_rb", {12'h0, de_rb}, 16'h5);
    chk("t3_has_imm", {15'h0, de_has_imm}, 16'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Overflow when a second instruction lands unacked; sticky afterwards.
    word(16'h1001, 1'b0, 1'b0);
    word(16'h2002, 1'b0, 1'b0);
    chk("t4_ovf", {15'h0, de_ovf}, 16'h1);
    chk("t4_op", {12'h0, de_op}, 16'h2);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    chk("t4_ovf_sticky", {15'h0, de_ovf}, 16'h1);

    // Ack on the publish edge: no overflow, vld stays high.
    do_reset();
    word(16'h1001, 1'b0, 1'b0);
    word(16'h2002, 1'b0, 1'b1);
    chk("t4b_ovf", {15'h0, de_ovf}, 16'h0);
    chk("t4b_vld", {15'h0, de_vld}, 16'h1);
    chk("t4b_op", {12'h0, de_op}, 16'h2);

    // Redirect coincident with a word while an opcode is staged.
    word(16'h712F, 1'b0, 1'b1);
    word(16'h1111, 1'b1, 1'b0);
    chk("t5_vld", {15'h0, de_vld}, 16'h0);
    word(16'h6789, 1'b0, 1'b0);
    chk("t5_op", {12'h0, de_op}, 16'h6);
    chk("t5_rb", {12'h0, de_rb}, 16'h9);
    chk("t5_has_imm", {15'h0, de_has_imm}, 16'h0);

    // Asynchronous reset while holding and staging.
    word(16'h412F, 1'b0, 1'b0);
    chk("t6_pre_vld", {15'h0, de_vld}, 16'h1);
    do_reset();
    word(16'h2345, 1'b0, 1'b0);
    chk("t6_has_imm", {15'h0, de_has_imm}, 16'h0);
    chk("t6_op", {12'h0, de_op}, 16'h2);
    tick(1'b0, 16'h0, 1'b0, 1'b1);

`ifdef IDLI_DE_PC_EN
    // PC wraps across the opcode/immediate pair.
    do_reset();
    rpc = 16'hFFFF;
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    word(16'h0F0F, 1'b0, 1'b0);
    word(16'h0000, 1'b0, 1'b0);
    chk("pc_first", de_pc, 16'hFFFF);
    chk("pc_first_imm", {15'h0, de_has_imm}, 16'h1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    word(16'h1234, 1'b0, 1'b0);
    chk("pc_second", de_pc, 16'h0001);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      logic  v, r, a;
      data_t w;
      if (i == 600) do_reset();
      v = (ctr_cnt == 2'd3) && ($urandom_range(0, 3) != 0);
      w = 16'($urandom);
      if ($urandom_range(0, 9) < 4) w[3:0] = 4'hF;
      r = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 2) == 0);
`ifdef IDLI_DE_PC_EN
      rpc = 16'($urandom);
`endif
      tick(v, w, r, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
